multicycle_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle core top.
- Sequences an RV32I subset through an FSM over separate instruction-memory and data-memory request/acknowledge ports.
- Holds its own PC, register file and ALU.
- Sits at the core level; memories and any bus fabric live outside.

---
 rtl/multicycle_pkg.sv | 78 +++++++
 rtl/multicycle_if.sv | 35 +++
 rtl/mc_regfile.sv | 40 ++++
 rtl/multicycle_core.sv | 264 ++++++++++++++++++++++++++
 tb/tb_multicycle_core.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_pkg
// Shared definitions for the multi-cycle RV32I-subset core:
//   - RV32I opcode, funct3 and funct7 constants for the supported subset
//   - alu_op_t : operations of the combinational ALU inside the core
//   - state_t  : FETCH / DECODE / EXEC / MEM / WB / TRAP sequencer states
//   - alu_op_from_funct() : funct3 + "alternate" bit to ALU operation
// -----------------------------------------------------------------------------
package multicycle_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // funct3 for ALU operations
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 for branches
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // funct7: the alternate encoding selects SUB / SRA / SRAI
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_PASS_B
    } alu_op_t;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_t;

    // alt = 1 selects SUB for funct3 000 and SRA for funct3 101.
    function automatic alu_op_t alu_op_from_funct(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        op = ALU_ADD;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_if.sv
// -----------------------------------------------------------------------------
// multicycle_if
// Instruction- and data-memory request/acknowledge bundle of the core.
//   imem_req/imem_addr      core -> memory, fetch request held until ack
//   imem_ack/imem_rdata     memory -> core, instruction word valid with ack
//   dmem_req/dmem_we        core -> memory, data request (we=1 store)
//   dmem_addr/dmem_wdata    core -> memory, word address and store data
//   dmem_ack/dmem_rdata     memory -> core, load data valid with ack
// Modports: master (core side), slave (memory side).
// -----------------------------------------------------------------------------
interface multicycle_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mc_regfile.sv
// -----------------------------------------------------------------------------
// mc_regfile
// Architectural register file: NREGS x XLEN, x0 reads as zero.
//   clk, reset          rising-edge clock, synchronous active-low clear
//   rs1_addr/rs1_data   combinational read port 1
//   rs2_addr/rs2_data   combinational read port 2
//   we/rd_addr/rd_data  synchronous write port (writes to x0 are dropped)
// -----------------------------------------------------------------------------
module mc_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] rs1_addr,
    output logic [XLEN-1:0]          rs1_data,
    input  logic [$clog2(NREGS)-1:0] rs2_addr,
    output logic [XLEN-1:0]          rs2_data,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] rd_addr,
    input  logic [XLEN-1:0]          rd_data
);
    logic [XLEN-1:0] regs [NREGS];

    // NOTE: clearing an array on reset maps it to flops rather than RAM; that
    // is wanted here because software relies on every register starting at 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (rd_addr != '0)) begin
            regs[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/multicycle_core.sv
// -----------------------------------------------------------------------------
// multicycle_core
// Multi-cycle RV32I-subset core: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
//   clk      rising-edge core clock
//   reset    synchronous active-low reset
//   bus      multicycle_if.master: imem and dmem request/acknowledge ports
//   pc_o     current PC (debug)
//   instret  retired-instruction counter, wraps at 2^32
//   halted   core stopped in TRAP
// Build option: define MULTICYCLE_TRAP_ILLEGAL_EN to send unsupported opcodes
// to TRAP; otherwise they retire as NOPs and halted is tied low.
// -----------------------------------------------------------------------------
module multicycle_core
    import multicycle_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_if.master        bus,
    output logic [XLEN-1:0]     pc_o,
    output logic [31:0]         instret,
    output logic                halted
);
    localparam int unsigned RW = $clog2(NREGS);
    localparam int unsigned SW = $clog2(XLEN);

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            retire;
    logic            rf_we;

    // Registered request outputs
    logic imem_req_q, dmem_req_q, dmem_we_q;

    // Datapath registers
    logic [31:0]     ir_q;
    logic [XLEN-1:0] a_q, b_q, imm_q, y_q, mdr_q;

    // Instruction fields
    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd;
    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign f7     = ir_q[31:25];

    logic is_r, is_i, is_lui, is_load, is_store, is_branch, is_jal, legal;
    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_lui    = (opcode == OP_LUI);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign legal     = is_r | is_i | is_lui | is_load | is_store | is_branch | is_jal;

    // Register file
    logic [XLEN-1:0] rs1_data, rs2_data;

    mc_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (RW'(ir_q[19:15])),
        .rs1_data (rs1_data),
        .rs2_addr (RW'(ir_q[24:20])),
        .rs2_data (rs2_data),
        .we       (rf_we),
        .rd_addr  (RW'(rd)),
        .rd_data  (is_load ? mdr_q : y_q)
    );

    // Immediate: built as 32 bits, then sign-extended to XLEN
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;

    always_comb begin
        imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
        case (opcode)
            OP_STORE:  imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OP_BRANCH: imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            OP_LUI:    imm32 = {ir_q[31:12], 12'b0};
            OP_JAL:    imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default:   ;
        endcase
    end
    assign imm_ext = XLEN'($signed(imm32));

    // ALU operand and operation select
    alu_op_t         alu_op;
    logic [XLEN-1:0] alu_a, alu_b, alu_y;
    logic [SW-1:0]   shamt;

    // NOTE: every signal an always_comb block writes gets a default first, so
    // no path through the case/if leaves it unassigned and infers a latch.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = a_q;
        alu_b  = imm_q;
        if (is_r) begin
            alu_b  = b_q;
            alu_op = alu_op_from_funct(f3, f7 == F7_ALT);
        end else if (is_i) begin
            // Only SRAI uses the alternate bit; ADDI has no subtract form.
            alu_op = alu_op_from_funct(f3, (f3 == F3_SRL_SRA) && (f7 == F7_ALT));
        end else if (is_lui) begin
            alu_op = ALU_PASS_B;
        end else if (is_jal) begin
            alu_a = pc;
            alu_b = XLEN'(4);
        end
    end

    assign shamt = alu_b[SW-1:0];

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD:    alu_y = alu_a + alu_b;
            ALU_SUB:    alu_y = alu_a - alu_b;
            ALU_AND:    alu_y = alu_a & alu_b;
            ALU_OR:     alu_y = alu_a | alu_b;
            ALU_XOR:    alu_y = alu_a ^ alu_b;
            ALU_SLT:    alu_y = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:   alu_y = {{(XLEN-1){1'b0}}, alu_a < alu_b};
            ALU_SLL:    alu_y = alu_a << shamt;
            ALU_SRL:    alu_y = alu_a >> shamt;
            ALU_SRA:    alu_y = $unsigned($signed(alu_a) >>> shamt);
            ALU_PASS_B: alu_y = alu_b;
            default:    alu_y = '0;
        endcase
    end

    logic branch_taken;
    assign branch_taken = (f3 == F3_BNE) ? (a_q != b_q) : (a_q == b_q);

    // Acks only count while our own request is up; stray acks are ignored.
    logic imem_done, dmem_done;
    assign imem_done = imem_req_q && bus.imem_ack;
    assign dmem_done = dmem_req_q && bus.dmem_ack;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        retire  = 1'b0;
        rf_we   = 1'b0;
        case (state)
            FETCH: begin
                if (imem_done) state_n = DECODE;
            end
            DECODE: begin
                if (legal) begin
                    state_n = EXEC;
                end else begin
`ifdef MULTICYCLE_TRAP_ILLEGAL_EN
                    state_n = TRAP;
`else
                    pc_n    = pc + XLEN'(4);
                    retire  = 1'b1;
                    state_n = FETCH;
`endif
                end
            end
            EXEC: begin
                if (is_branch) begin
                    pc_n    = branch_taken ? (pc + imm_q) : (pc + XLEN'(4));
                    retire  = 1'b1;
                    state_n = FETCH;
                end else if (is_jal) begin
                    // Link value goes through Y; WB leaves PC alone for JAL.
                    pc_n    = pc + imm_q;
                    state_n = WB;
                end else if (is_load || is_store) begin
                    state_n = MEM;
                end else begin
                    state_n = WB;
                end
            end
            MEM: begin
                if (dmem_done) begin
                    if (is_store) begin
                        pc_n    = pc + XLEN'(4);
                        retire  = 1'b1;
                        state_n = FETCH;
                    end else begin
                        state_n = WB;
                    end
                end
            end
            WB: begin
                rf_we   = (rd != 5'd0);
                pc_n    = is_jal ? pc : (pc + XLEN'(4));
                retire  = 1'b1;
                state_n = FETCH;
            end
            TRAP: begin
                state_n = TRAP;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // Architectural control state and registered request outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc         <= RESET_PC;
            instret    <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
        end else begin
            pc <= pc_n;
            if (retire) instret <= instret + 32'd1;
            imem_req_q <= (state_n == FETCH);
            dmem_req_q <= (state_n == MEM);
            dmem_we_q  <= (state_n == MEM) && is_store;
        end
    end

    // Datapath registers: always written before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if ((state == FETCH) && imem_done) ir_q <= bus.imem_rdata;
        if (state == DECODE) begin
            a_q   <= rs1_data;
            b_q   <= rs2_data;
            imm_q <= imm_ext;
        end
        if (state == EXEC) y_q <= alu_y;
        if ((state == MEM) && dmem_done) mdr_q <= bus.dmem_rdata;
    end

    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = y_q;
    assign bus.dmem_wdata = b_q;
    assign pc_o           = pc;

`ifdef MULTICYCLE_TRAP_ILLEGAL_EN
    assign halted = (state == TRAP);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// -----------------------------------------------------------------------------
// tb_multicycle_core
// Directed bench for multicycle_core (RESET_PC = 0x100). A small memory
// responder answers fetches with zero wait and data requests after two wait
// cycles; dhold withholds data acks and dstale forces a stray data ack.
// -----------------------------------------------------------------------------
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_o;
    logic [31:0] instret;
    logic        halted;

    int n_assert = 0;
    int n_fail   = 0;

    logic        dhold  = 1'b0;
    logic        dstale = 1'b0;
    int          dcnt   = 0;

    logic [31:0] imem [256];
    logic [31:0] dmem [64] = '{default: '0};

    multicycle_if #(.XLEN(32)) bus ();

    multicycle_core #(
        .XLEN     (32),
        .NREGS    (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .pc_o    (pc_o),
        .instret (instret),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    // Memory responder: decides acks on the falling edge for the next rising edge.
    always @(negedge clk) begin
        logic dack;
        bus.imem_ack   = bus.imem_req;
        bus.imem_rdata = bus.imem_req ? imem[bus.imem_addr[9:2]] : 32'h0;
        dack = 1'b0;
        if (bus.dmem_req) begin
            if (!dhold && dcnt == 2) begin
                dack = 1'b1;
                if (bus.dmem_we) dmem[bus.dmem_addr[7:2]] = bus.dmem_wdata;
                bus.dmem_rdata = dmem[bus.dmem_addr[7:2]];
            end
            dcnt++;
        end else begin
            dcnt = 0;
        end
        bus.dmem_ack = dack | dstale;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
        imem[64] = 32'h0050_0093;  // 0x100 ADDI x1,x0,5
        imem[65] = 32'hFFD0_0113;  // 0x104 ADDI x2,x0,-3
        imem[66] = 32'h0020_81B3;  // 0x108 ADD  x3,x1,x2
        imem[67] = 32'h4011_0233;  // 0x10C SUB  x4,x2,x1
        imem[68] = 32'h0070_0013;  // 0x110 ADDI x0,x0,7
        imem[69] = 32'h0430_2023;  // 0x114 SW   x3,0x40(x0)
        imem[70] = 32'h0400_2283;  // 0x118 LW   x5,0x40(x0)
        imem[71] = 32'hEF5F_F3EF;  // 0x11C JAL  x7,-0x10C -> 0x10
        imem[4]  = 32'h0010_8463;  // 0x10  BEQ  x1,x1,+8
        imem[6]  = 32'h0010_9463;  // 0x18  BNE  x1,x1,+8
        imem[7]  = 32'h0090_0413;  // 0x1C  ADDI x8,x0,9
        imem[8]  = 32'hFF1F_F36F;  // 0x20  JAL  x6,-16

        // Reset held for three edges
        tick();
        check("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        tick();
        tick();
        check("rst_instret", instret, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        reset = 1'b1;
        tick();
        check("boot_imem_req", 32'(bus.imem_req), 32'd1);
        check("boot_imem_addr", bus.imem_addr, 32'h100);
        check("boot_instret", instret, 32'd0);

        // ALU sequence, 4 cycles each
        repeat (16) tick();
        check("alu_instret", instret, 32'd4);
        check("alu_x1", dut.u_regfile.regs[1], 32'd5);
        check("alu_x2", dut.u_regfile.regs[2], 32'hFFFF_FFFD);
        check("alu_x3", dut.u_regfile.regs[3], 32'd2);
        check("alu_x4", dut.u_regfile.regs[4], 32'hFFFF_FFF8);
        repeat (4) tick();
        check("x0_instret", instret, 32'd5);
        check("x0_zero", dut.u_regfile.regs[0], 32'd0);
        check("x0_pc", pc_o, 32'h114);

        // SW with two data wait cycles
        repeat (3) tick();
        check("sw_req", 32'(bus.dmem_req), 32'd1);
        check("sw_we", 32'(bus.dmem_we), 32'd1);
        check("sw_addr", bus.dmem_addr, 32'h40);
        check("sw_wdata", bus.dmem_wdata, 32'd2);
        repeat (3) tick();
        check("sw_instret", instret, 32'd6);
        check("sw_req_drop", 32'(bus.dmem_req), 32'd0);
        check("sw_next_pc", bus.imem_addr, 32'h118);

        // LW: 7 cycles in total
        repeat (3) tick();
        check("lw_req", 32'(bus.dmem_req), 32'd1);
        check("lw_we", 32'(bus.dmem_we), 32'd0);
        check("lw_addr", bus.dmem_addr, 32'h40);
        repeat (4) tick();
        check("lw_instret", instret, 32'd7);
        check("lw_x5", dut.u_regfile.regs[5], 32'd2);

        // JAL back to 0x10, then branches, then JAL -16
        repeat (4) tick();
        check("jal1_pc", pc_o, 32'h10);
        check("jal1_req", 32'(bus.imem_req), 32'd1);
        check("jal1_x7", dut.u_regfile.regs[7], 32'h120);
        check("jal1_instret", instret, 32'd8);
        repeat (3) tick();
        check("beq_target", bus.imem_addr, 32'h18);
        check("beq_instret", instret, 32'd9);
        repeat (3) tick();
        check("bne_fallthru", bus.imem_addr, 32'h1C);
        check("bne_instret", instret, 32'd10);
        repeat (4) tick();
        check("addi_x8", dut.u_regfile.regs[8], 32'd9);
        check("addi_pc", bus.imem_addr, 32'h20);
        repeat (4) tick();
        check("jal2_x6", dut.u_regfile.regs[6], 32'h24);
        check("jal2_target", bus.imem_addr, 32'h10);
        check("jal2_instret", instret, 32'd12);

        // Reset clears registers; rerun until SW stalls in MEM
        dhold = 1'b1;
        reset = 1'b0;
        tick();
        check("rst2_x6", dut.u_regfile.regs[6], 32'd0);
        check("rst2_instret", instret, 32'd0);
        check("rst2_imem_req", 32'(bus.imem_req), 32'd0);
        reset = 1'b1;
        tick();
        check("rst2_boot_addr", bus.imem_addr, 32'h100);
        repeat (23) tick();
        check("stall_req", 32'(bus.dmem_req), 32'd1);
        check("stall_instret", instret, 32'd5);
        repeat (2) tick();
        check("stall_hold", 32'(bus.dmem_req), 32'd1);

        // Reset mid-MEM, stale ack, then illegal opcode at RESET_PC
        imem[64] = 32'h0000_0000;
        reset = 1'b0;
        tick();
        check("mid_dmem_req", 32'(bus.dmem_req), 32'd0);
        check("mid_imem_req", 32'(bus.imem_req), 32'd0);
        check("mid_pc", pc_o, 32'h100);
        dstale = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("stale_imem_req", 32'(bus.imem_req), 32'd1);
        check("stale_imem_addr", bus.imem_addr, 32'h100);
        check("stale_dmem_req", 32'(bus.dmem_req), 32'd0);
        check("stale_instret", instret, 32'd0);
        repeat (2) tick();
`ifdef MULTICYCLE_TRAP_ILLEGAL_EN
        check("trap_halted", 32'(halted), 32'd1);
        check("trap_pc", pc_o, 32'h100);
        check("trap_imem_req", 32'(bus.imem_req), 32'd0);
        check("trap_instret", instret, 32'd0);
        repeat (3) tick();
        check("trap_stay_halted", 32'(halted), 32'd1);
        check("trap_stay_pc", pc_o, 32'h100);
        check("trap_stay_req", 32'(bus.imem_req), 32'd0);
`else
        check("nop_halted", 32'(halted), 32'd0);
        check("nop_pc", bus.imem_addr, 32'h104);
        check("nop_imem_req", 32'(bus.imem_req), 32'd1);
        check("nop_instret", instret, 32'd1);
        check("nop_dmem_req", 32'(bus.dmem_req), 32'd0);
`endif
        dstale = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
